// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Instruction-fetch stage. Owns the program counter and the IF/ID pipeline
// register, runs a request/ready handshake to instruction memory, and handles
// hazard stalls, redirect flushes and discarding of stale in-flight responses.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : a misaligned JumpReg target pulses misalign and parks the
//               unit in TRAP (left only by reset).
//   undefined : JumpReg target has bits [1:0] cleared, misalign is tied 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   branch_Or_Jump        next-PC select from ID (0 seq, 1 br, 2 j, 3 jr)
//   redirect_pc_plus4     PC+4 of the deciding ID instruction
//   branch_offset         sign-extended branch immediate (words)
//   jump_index            J-type index field
//   jump_reg              rs value for JumpReg
//   stall                 freezes PC and IF/ID
//   imem_req/imem_addr    fetch request and address
//   imem_ready/imem_rdata response valid and instruction word
//   ifid_valid/ifid_instr/ifid_pc_plus4  IF/ID register contents
//   fetch_pc              current PC
//   misalign              one-cycle misaligned JumpReg trap pulse
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  branch_Or_Jump,
    input  logic [31:0] redirect_pc_plus4,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_index,
    input  logic [31:0] jump_reg,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] fetch_pc,
    output logic        misalign
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DROP  = 3'd2,
        HOLD  = 3'd3
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        TRAP  = 3'd4
`endif
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic [31:0] hold_word;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        redirect;

    // The PC never moves while a request is outstanding (the redirect target
    // waits in pend_pc), so the fetch address is simply the PC register.
    assign fetch_pc  = pc;
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // A redirect from ID only counts when ID is not stalled; a stalled ID
    // will present the same decision again.
    assign redirect = (branch_Or_Jump != 2'd0) && !stall;

    // Next-PC target for each redirect kind, all wrapping modulo 2^32.
    always_comb begin
        target = 32'h0000_0000;
        case (branch_Or_Jump)
            2'd1:    target = redirect_pc_plus4 + (branch_offset << 2);
            2'd2:    target = {redirect_pc_plus4[31:28], jump_index, 2'b00};
            2'd3:    target = jump_reg & 32'hFFFF_FFFC;
            default: target = 32'h0000_0000;
        endcase
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic bad_jr;
    logic trap_pend;
    logic misalign_q;

    // Misaligned JumpReg is detected on the same terms as any redirect.
    assign bad_jr   = redirect && (branch_Or_Jump == 2'd3) && (jump_reg[1:0] != 2'b00);
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    // Fetch FSM: owns PC, IF/ID, the pending redirect target and the word
    // buffered while ID is stalled. imem_req is registered and follows the
    // state being entered (high in FETCH and DROP only).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            pend_pc       <= 32'h0000_0000;
            hold_word     <= 32'h0000_0000;
            imem_req      <= 1'b0;
            ifid_valid    <= 1'b0;
            ifid_instr    <= 32'h0000_0000;
            ifid_pc_plus4 <= 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
            trap_pend     <= 1'b0;
            misalign_q    <= 1'b0;
`endif
        end else begin
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end

                FETCH: begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (bad_jr) begin
                        misalign_q <= 1'b1;
                        ifid_valid <= 1'b0;
                        if (imem_ready) begin
                            state    <= TRAP;
                            imem_req <= 1'b0;
                        end else begin
                            trap_pend <= 1'b1;
                            state     <= DROP;
                        end
                    end else
`endif
                    if (redirect && imem_ready) begin
                        pc         <= target;
                        ifid_valid <= 1'b0;
                    end else if (redirect) begin
                        pend_pc    <= target;
                        ifid_valid <= 1'b0;
                        state      <= DROP;
                    end else if (stall && imem_ready) begin
                        hold_word <= imem_rdata;
                        imem_req  <= 1'b0;
                        state     <= HOLD;
                    end else if (stall) begin
                        state <= FETCH;
                    end else if (imem_ready) begin
                        ifid_valid    <= 1'b1;
                        ifid_instr    <= imem_rdata;
                        ifid_pc_plus4 <= pc_plus4;
                        pc            <= pc_plus4;
                    end else begin
                        ifid_valid <= 1'b0;
                    end
                end

                // The stale request must complete before the target is issued;
                // its data is thrown away and a newer redirect wins.
                DROP: begin
                    ifid_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (bad_jr) begin
                        misalign_q <= 1'b1;
                        trap_pend  <= 1'b1;
                    end
                    if (imem_ready && (trap_pend || bad_jr)) begin
                        state    <= TRAP;
                        imem_req <= 1'b0;
                    end else
`endif
                    if (imem_ready) begin
                        pc    <= redirect ? target : pend_pc;
                        state <= FETCH;
                    end else if (redirect) begin
                        pend_pc <= target;
                    end
                end

                // The word fetched during the stall waits here so it is neither
                // lost nor fetched twice.
                HOLD: begin
                    if (!stall) begin
`ifdef FETCH_ALIGN_CHECK_EN
                        if (bad_jr) begin
                            misalign_q <= 1'b1;
                            ifid_valid <= 1'b0;
                            state      <= TRAP;
                        end else
`endif
                        if (redirect) begin
                            pc         <= target;
                            ifid_valid <= 1'b0;
                            imem_req   <= 1'b1;
                            state      <= FETCH;
                        end else begin
                            ifid_valid    <= 1'b1;
                            ifid_instr    <= hold_word;
                            ifid_pc_plus4 <= pc_plus4;
                            pc            <= pc_plus4;
                            imem_req      <= 1'b1;
                            state         <= FETCH;
                        end
                    end
                end

`ifdef FETCH_ALIGN_CHECK_EN
                TRAP: begin
                    imem_req   <= 1'b0;
                    ifid_valid <= 1'b0;
                end
`endif

                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
